// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions for the memory-bus responder and the arbiter.
// Provides the response codes and the responder FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    R_WAIT,
    R_RESP,
    W_WAIT,
    W_RESP
  } state_t;

endpackage

// File: rtl/axi_lite_sram_if.sv
// AXI-lite style bus bundle (ar/r/aw/w/b channels) between the arbiter
// (master) and the SRAM responder (slave).
//   ar: araddr, arvalid -> / <- arready
//   r : <- rdata, rresp, rvalid / rready ->
//   aw: awaddr, awvalid -> / <- awready
//   w : wdata, wstrb, wvalid -> / <- wready
//   b : <- bresp, bvalid / bready ->
interface axi_lite_sram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram_array.sv
// sram_array: DEPTH x DATA_W word array, synchronous byte-strobed write
// port and asynchronous read port, both indexed by word.
//   clk    : clock
//   we     : write enable (qualified by wstrb per byte lane)
//   waddr  : write word index
//   wdata  : write data
//   wstrb  : byte lane enables
//   raddr  : read word index
//   rdata  : read data (combinational)
module sram_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI-lite style responder backing the CPU memory bus with
// an internal word array and a fixed, programmable response latency.
// One transaction in flight; reads win over writes when both request.
//   clk : clock
//   rst : synchronous active-high reset (control and response outputs)
//   bus : slave side of the ar/r/aw/w/b bundle
// Response valid rises LATENCY+1 cycles after the accept edge: the FSM
// reaches R_RESP/W_RESP after LATENCY cycles and raises valid one cycle
// later from a register.
module axi_lite_sram
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 64,
  parameter int                DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                LATENCY = 1
) (
  input logic             clk,
  input logic             rst,
  axi_lite_sram_if.slave  bus
);
  localparam int                IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH * 8);
  localparam logic [3:0]        LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic              rvalid_q;
  logic              bvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [1:0]        bresp_q;

  logic [IDX_W-1:0]  ar_idx;
  logic [IDX_W-1:0]  aw_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              ar_err;
  logic              aw_err;
  logic              rd_err;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_data;
  logic              idle;
  logic              rd_acc;
  logic              wr_acc;
  logic              we;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a < BASE) || (off >= SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return IDX_W'(off >> 3);
  endfunction

  assign ar_idx = addr_idx(bus.araddr);
  assign aw_idx = addr_idx(bus.awaddr);
  assign ar_err = addr_err(bus.araddr);
  assign aw_err = addr_err(bus.awaddr);

  assign idle        = (state == IDLE) && !rst;
  assign bus.arready = idle;
  assign bus.awready = idle && !bus.arvalid && bus.awvalid && bus.wvalid;
  assign bus.wready  = bus.awready;

  assign rd_acc = bus.arvalid && bus.arready;
  assign wr_acc = bus.awvalid && bus.wvalid && bus.awready;
  assign we     = wr_acc && !aw_err;

  // With LATENCY==0 the data is captured on the accept edge itself, so the
  // read port must look at the live address rather than the latched one.
  assign rd_idx  = (state == IDLE) ? ar_idx : idx_q;
  assign rd_err  = (state == IDLE) ? ar_err : err_q;
  assign rd_data = rd_err ? '0 : arr_rdata;

  sram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (aw_idx),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc) begin
            idx_q <= ar_idx;
            err_q <= ar_err;
            cnt   <= LAT_M1;
            if (LATENCY == 0) begin
              state   <= R_RESP;
              rdata_q <= rd_data;
              rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
              state <= R_WAIT;
            end
          end else if (wr_acc) begin
            err_q <= aw_err;
            cnt   <= LAT_M1;
            state <= (LATENCY == 0) ? W_RESP : W_WAIT;
          end
        end
        R_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= R_RESP;
            rdata_q <= rd_data;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        W_WAIT: begin
          if (cnt == 4'd0) state <= W_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        R_RESP: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
          end else if (bus.rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        W_RESP: begin
          if (!bvalid_q) begin
            bvalid_q <= 1'b1;
            bresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
          end else if (bus.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;
  assign bus.bvalid = bvalid_q;
  assign bus.bresp  = bresp_q;

endmodule
